count_display: RTL and testbench

Downstream display stage for the 4-bit up-counter. It takes the counter's `count[3:0]` output and shows it as a decimal value from 00 to 15 on a two-digit, multiplexed, common-anode 7-segment display. The tens digit is blanked when it would be zero. It also flags counter wrap-around (15→0) by lighting the ones-digit decimal point for a programmable number of scan frames.

---
 rtl/count_display.sv | 121 ++++++++++++
 tb/tb_count_display.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_display.sv
// rtl/count_display.sv - two-digit multiplexed common-anode 7-segment display of a 4-bit count with wrap indicator
module count_display #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic       clock,
    input  logic       res,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp
);

    localparam int             SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0]  SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [7:0]     HOLD_INIT = 8'(HOLD_FRAMES);

    logic [SW-1:0] r_scan_cnt;
    logic          r_digit;
    logic [3:0]    r_disp_val;
    logic [3:0]    r_prev_count;
    logic [7:0]    r_hold;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;
    logic          r_dp;

    logic          w_scan_last;
    logic          w_frame_end;
    logic          w_wrap;
    logic          w_tens;
    logic [3:0]    w_ones;

    // Segment pattern in gfedcba order, active-high (inverted at the output register)
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    assign w_scan_last = (r_scan_cnt == SCAN_LAST);
    assign w_frame_end = w_scan_last && r_digit;
    // Counter reset forcing 15 -> 0 also counts as a wrap
    assign w_wrap      = (r_prev_count == 4'hF) && (count == 4'h0);
    assign w_tens      = (r_disp_val >= 4'd10);
    assign w_ones      = w_tens ? (r_disp_val - 4'd10) : r_disp_val;

    // Scan timer: each digit is driven for SCAN_DIV cycles, ones digit first
    always_ff @(posedge clock) begin
        if (res) begin
            r_scan_cnt <= '0;
            r_digit    <= 1'b0;
        end else if (w_scan_last) begin
            r_scan_cnt <= '0;
            r_digit    <= ~r_digit;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    // Frame latch: one sample per frame so both digits always agree
    always_ff @(posedge clock) begin
        if (res) begin
            r_disp_val <= 4'd0;
        end else if (w_frame_end) begin
            r_disp_val <= count;
        end
    end

    // Wrap detect and hold: reload on wrap, otherwise count down once per frame
    always_ff @(posedge clock) begin
        if (res) begin
            r_prev_count <= 4'd0;
            r_hold       <= 8'd0;
        end else begin
            r_prev_count <= count;
            if (w_wrap) begin
                r_hold <= HOLD_INIT;
            end else if (w_frame_end && (r_hold != 8'd0)) begin
                r_hold <= r_hold - 8'd1;
            end
        end
    end

    // Output register: drive the selected digit, blanking a zero tens digit
    always_ff @(posedge clock) begin
        if (res) begin
            r_seg <= 7'b1111111;
            r_an  <= 2'b11;
            r_dp  <= 1'b1;
        end else if (!r_digit) begin
            r_seg <= ~seg_pattern(w_ones);
            r_an  <= 2'b10;
            r_dp  <= ~(r_hold != 8'd0);
        end else if (w_tens) begin
            r_seg <= ~seg_pattern(4'd1);
            r_an  <= 2'b01;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= 7'b1111111;
            r_an  <= 2'b11;
            r_dp  <= 1'b1;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule

// File: tb/tb_count_display.sv
// tb/tb_count_display.sv - randomized and directed self-checking bench for count_display
module tb_count_display;

    localparam int SD = 4;
    localparam int HF = 2;

    logic       clock = 1'b0;
    logic       res   = 1'b1;
    logic [3:0] count = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    count_display #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clock (clock),
        .res   (res),
        .count (count),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles since reset, value shown this frame, frames of hold left
    int         m_t;
    int         m_val;
    int         m_hold;
    int         m_prev;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_dp;
    logic [6:0] pat [0:9];

    // Advance one clock; expectations come from the model state before the edge
    task automatic step();
        int phase;
        @(posedge clock);
        if (res) begin
            e_seg = 7'b1111111; e_an = 2'b11; e_dp = 1'b1;
            m_t = 0; m_val = 0; m_hold = 0; m_prev = 0;
        end else begin
            phase = m_t % (2 * SD);
            if (phase < SD) begin
                e_an = 2'b10; e_seg = ~pat[m_val % 10]; e_dp = (m_hold == 0);
            end else if (m_val >= 10) begin
                e_an = 2'b01; e_seg = ~pat[1]; e_dp = 1'b1;
            end else begin
                e_an = 2'b11; e_seg = 7'b1111111; e_dp = 1'b1;
            end
            if (m_prev == 15 && count == 4'd0) m_hold = HF;
            else if (phase == 2 * SD - 1 && m_hold > 0) m_hold = m_hold - 1;
            if (phase == 2 * SD - 1) m_val = int'(count);
            m_prev = int'(count);
            m_t++;
        end
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1; count = 4'd0;
        repeat (2) begin
            step();
            checks++;
            if (seg !== 7'b1111111 || an !== 2'b11 || dp !== 1'b1) begin
                errors++;
                $display("FAIL reset_state seg=%b an=%b dp=%b expected seg=1111111 an=11 dp=1", seg, an, dp);
            end
        end
        res = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (i < 4 && (an !== 2'b10 || seg !== 7'b1000000 || dp !== 1'b1)) begin
                errors++;
                $display("FAIL release_ones i=%0d seg=%b an=%b dp=%b expected seg=1000000 an=10 dp=1", i, seg, an, dp);
            end else if (i >= 4 && an !== 2'b11) begin
                errors++;
                $display("FAIL release_tens_blank i=%0d an=%b expected an=11", i, an);
            end
        end
    endtask

    task automatic test_static(input logic [3:0] v, input logic [6:0] ones_seg, input logic tens_on);
        count = v;
        for (int i = 0; i < 6 * SD; i++) begin
            step();
            checks++;
            if ({seg, an, dp} !== {e_seg, e_an, e_dp}) begin
                errors++;
                $display("FAIL static_%0d_model seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b", v, seg, an, dp, e_seg, e_an, e_dp);
            end
        end
        for (int i = 0; i < 2 * SD; i++) begin
            step();
            checks++;
            if ((m_t - 1) % (2 * SD) < SD) begin
                if (seg !== ones_seg || an !== 2'b10 || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL static_%0d_ones seg=%b an=%b dp=%b expected seg=%b an=10 dp=1", v, seg, an, dp, ones_seg);
                end
            end else if (tens_on) begin
                if (seg !== 7'b1111001 || an !== 2'b01) begin
                    errors++;
                    $display("FAIL static_%0d_tens seg=%b an=%b expected seg=1111001 an=01", v, seg, an);
                end
            end else if (an !== 2'b11 || seg !== 7'b1111111) begin
                errors++;
                $display("FAIL static_%0d_blank seg=%b an=%b expected seg=1111111 an=11", v, seg, an);
            end
        end
    endtask

    task automatic test_midframe_change();
        int guard;
        count = 4'd3;
        repeat (4 * SD) step();
        guard = 0;
        while (m_t % (2 * SD) != SD + 1 && guard < 4 * SD) begin step(); guard++; end
        count = 4'd9;
        // Rest of the current frame still shows 3
        for (int i = 0; i < SD - 1; i++) begin
            step();
            checks++;
            if ({seg, an, dp} !== {e_seg, e_an, e_dp} || an !== 2'b11) begin
                errors++;
                $display("FAIL midframe_old seg=%b an=%b dp=%b expected seg=%b an=11 dp=%b", seg, an, dp, e_seg, e_dp);
            end
        end
        step();
        checks++;
        if (seg !== 7'b0010000 || an !== 2'b10) begin
            errors++;
            $display("FAIL midframe_new seg=%b an=%b expected seg=0010000 an=10", seg, an);
        end
    endtask

    task automatic test_wrap();
        int lit;
        count = 4'd14; step();
        count = 4'd15; step();
        count = 4'd0;  step();
        lit = 0;
        for (int i = 0; i < 5 * 2 * SD; i++) begin
            step();
            if (dp === 1'b0) lit++;
            checks++;
            if ({seg, an, dp} !== {e_seg, e_an, e_dp}) begin
                errors++;
                $display("FAIL wrap_model seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b", seg, an, dp, e_seg, e_an, e_dp);
            end
            // Second wrap while the first hold is still running
            if (i == 2 * SD) begin count = 4'd15; step(); count = 4'd0; end
        end
        checks++;
        if (lit < 2 * SD) begin
            errors++;
            $display("FAIL wrap_dp_lit_cycles got=%0d expected_at_least=%0d", lit, 2 * SD);
        end
        checks++;
        if (dp !== 1'b1 || m_hold != 0) begin
            errors++;
            $display("FAIL wrap_dp_expired dp=%b expected dp=1", dp);
        end
    endtask

    task automatic test_reset_midop();
        count = 4'd15; step();
        count = 4'd0;  step();
        count = 4'd12;
        repeat (SD + 1) step();
        res = 1'b1;
        step();
        checks++;
        if (seg !== 7'b1111111 || an !== 2'b11 || dp !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset seg=%b an=%b dp=%b expected seg=1111111 an=11 dp=1", seg, an, dp);
        end
        res = 1'b0;
        step();
        checks++;
        if (seg !== 7'b1000000 || an !== 2'b10 || dp !== 1'b1) begin
            errors++;
            $display("FAIL midop_release seg=%b an=%b dp=%b expected seg=1000000 an=10 dp=1", seg, an, dp);
        end
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            checks++;
            if ({seg, an, dp} !== {e_seg, e_an, e_dp}) begin
                errors++;
                $display("FAIL midop_model seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b", seg, an, dp, e_seg, e_an, e_dp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       count = 4'd15;
                1:       count = (count == 4'd15) ? 4'd0 : count;
                2, 3:    count = 4'($urandom_range(0, 15));
                default: count = count;
            endcase
            res = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if ({seg, an, dp} !== {e_seg, e_an, e_dp}) begin
                errors++;
                $display("FAIL random_%0d seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b", i, seg, an, dp, e_seg, e_an, e_dp);
            end
        end
        res = 1'b0;
    endtask

    initial begin
        pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011; pat[3] = 7'b1001111;
        pat[4] = 7'b1100110; pat[5] = 7'b1101101; pat[6] = 7'b1111101; pat[7] = 7'b0000111;
        pat[8] = 7'b1111111; pat[9] = 7'b1101111;
        m_t = 0; m_val = 0; m_hold = 0; m_prev = 0;
        test_reset();
        test_static(4'd7, 7'b1111000, 1'b0);
        test_static(4'd12, 7'b0100100, 1'b1);
        test_midframe_change();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
